rgb_expand: RTL and testbench
=============================

Name: rgb_expand

Overview:
- Decode-side counterpart of the RGB compressor.
- Accepts a stream of 3-bit compressed colour codes (one bit per channel) over a valid/ready handshake.
- Expands each code back into REPEAT full-depth RGB pixels and tags each pixel with line and frame position markers.
- Feeds marker-overlay and display paths that need pixel-rate RGB reconstructed from compressed marker-detect output.

Parameters:
- COLOUR_DEPTH, 8, bits per colour channel; rgb_out is 3*COLOUR_DEPTH wide.
- REPEAT, 3, output pixels emitted per input code (matches the compressor's AVERAGE_OVER); must be >= 1.
- LOW_LEVEL, 0, channel value emitted for a code bit of 0.
- HIGH_LEVEL, 255, channel value emitted for a code bit of 1; must fit COLOUR_DEPTH bits.
- LINE_WIDTH, 640, output pixels per line; must be >= 1.
- NUM_LINES, 480, lines per frame; must be >= 1.

Ports:
- clk_in, input, 1, single clock, rising edge.
- rst_n_in, input, 1, asynchronous active-low reset.
- code_in, input, 3, compressed code: bit2 = R, bit1 = G, bit0 = B.
- code_valid_in, input, 1, code_in valid.
- code_ready_out, output, 1, block can accept code_in this cycle.
- frame_restart_in, input, 1, synchronous restart: drops pending pixels, zeroes position counters.
- rgb_out, output, 3*COLOUR_DEPTH, [top third] = R, [middle] = G, [bottom] = B.
- rgb_valid_out, output, 1, rgb_out valid.
- rgb_ready_in, input, 1, downstream accepts rgb_out.
- sof_out, output, 1, current pixel is column 0, line 0.
- eol_out, output, 1, current pixel is column LINE_WIDTH-1.
- eof_out, output, 1, current pixel is the last pixel of the frame.

Behaviour:
- Reset (rst_n_in low, asynchronous): busy=0, code_q=0, rep_cnt=0, col_cnt=0, line_cnt=0.
  - All outputs are 0, including code_ready_out, for as long as reset is asserted.
  - The block is operational from the first rising edge after release.
- State: busy (EMIT when 1, IDLE when 0), code_q[2:0], rep_cnt in 0..REPEAT-1, col_cnt, line_cnt. Counter widths are $clog2 of their range, minimum 1 bit.
- Handshake events:
  - in_fire = code_valid_in && code_ready_out.
  - out_fire = rgb_valid_out && rgb_ready_in.
  - last_rep = (rep_cnt == REPEAT-1).
- code_ready_out = !frame_restart_in && (!busy || (rgb_ready_in && last_rep)).
  - This is a combinational path from rgb_ready_in. It allows one code per REPEAT cycles with no bubble.
- Outputs while busy:
  - rgb_valid_out = busy.
  - rgb_out is built channel-wise from code_q: bit=1 gives HIGH_LEVEL, bit=0 gives LOW_LEVEL.
  - rgb_out, sof_out, eol_out and eof_out are all 0 when !busy.
- Latency: a code accepted on edge N presents its first pixel during the cycle following edge N.
- Each pixel remains stable while rgb_valid_out && !rgb_ready_in (standard valid/ready hold rule).
- Transitions on a clock edge, first matching rule wins:
  1. frame_restart_in=1: busy=0, rep_cnt=0, col_cnt=0, line_cnt=0. A pending out_fire in this cycle is discarded; counters still clear.
  2. in_fire: code_q=code_in, rep_cnt=0, busy=1. Covers both IDLE accept and back-to-back accept on the last repetition.
  3. out_fire && last_rep: busy=0, rep_cnt=0.
  4. out_fire: rep_cnt+1.
- Position counters, on each out_fire when not restarting:
  - col_cnt advances and wraps to 0 after LINE_WIDTH-1.
  - line_cnt advances on wrap and returns to 0 after NUM_LINES-1.
- Marker definitions:
  - sof_out = busy && col_cnt==0 && line_cnt==0.
  - eol_out = busy && col_cnt==LINE_WIDTH-1.
  - eof_out = eol_out && line_cnt==NUM_LINES-1.
- Codes straddle line boundaries freely; repetition and position counting are independent.
- REPEAT=1 degenerates to one pixel per code at full throughput.

Decomposition:
- Package rgb_pkg holds:
  - the code bit-index constants (R_BIT=2, G_BIT=1, B_BIT=0);
  - a function mapping one code bit to a COLOUR_DEPTH channel value given LOW/HIGH.
- One sub-module, frame_pos_counter, holds col_cnt/line_cnt with an advance and clear interface and produces sof/eol/eof.
- The repeat and handshake logic stays in rgb_expand.

Test Plan:
- Reset then single code 3'b101, rgb_ready_in=1: rgb_out=0xFF00FF for exactly 3 consecutive cycles, valid starting the cycle after accept; code_ready_out=1 only on the 3rd.
- Back-to-back codes 3'b010, 3'b001 with valid held high: 6 contiguous valid pixels (0x00FF00 ×3, then 0x0000FF ×3), no bubble.
- rgb_ready_in toggled 1,0,0,1,… on code 3'b111: rgb_out holds 0xFFFFFF through stalls; exactly 3 out_fires; code_ready_out=0 during stalls.
- LINE_WIDTH=4, NUM_LINES=2, 3 codes (9 pixels):
  - sof on pixel 0; eol on pixels 3 and 7; eof on pixel 7;
  - pixel 8 is col 0, line 0 with sof=1.
- frame_restart_in pulsed at rep_cnt=1 with code_valid_in high: code_ready_out=0, rgb_valid_out=0 next cycle, counters zero; the next accepted code's first pixel asserts sof.
- rst_n_in dropped mid-emission, asynchronously between edges: rgb_valid_out, rgb_out and code_ready_out go 0 immediately; after release the first code restarts at sof.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared constants, types and helpers for the RGB expander.
package rgb_pkg;

    // Bit positions of each colour channel inside a compressed code
    localparam int unsigned R_BIT = 2;
    localparam int unsigned G_BIT = 1;
    localparam int unsigned B_BIT = 0;

    // Expander state: IDLE waits for a code, EMIT is replaying a code
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Channel level for one code bit; callers size-cast to their channel depth
    function automatic int unsigned channel_level(
        input logic        code_bit,
        input int unsigned low,
        input int unsigned high
    );
        return code_bit ? high : low;
    endfunction

endpackage

// File: rtl/rgb_expand_frame_pos_counter.sv
// Column/line position tracker with start/end-of-line/frame markers.
module frame_pos_counter #(
    parameter int unsigned LINE_WIDTH = 640,
    parameter int unsigned NUM_LINES  = 480
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic active_in,
    input  logic advance_in,
    input  logic clear_in,
    output logic sof_out,
    output logic eol_out,
    output logic eof_out
);

    localparam int unsigned COL_W  = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int unsigned LINE_W = (NUM_LINES > 1)  ? $clog2(NUM_LINES)  : 1;

    logic [COL_W-1:0]  col_q,  col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              col_last;
    logic              line_last;

    assign col_last  = (col_q == COL_W'(LINE_WIDTH - 1));
    assign line_last = (line_q == LINE_W'(NUM_LINES - 1));

    // Next position: clear wins, otherwise step column and wrap into the line count
    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        if (clear_in) begin
            col_d  = '0;
            line_d = '0;
        end else if (advance_in) begin
            if (col_last) begin
                col_d  = '0;
                line_d = line_last ? '0 : line_q + LINE_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Position registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            col_q  <= '0;
            line_q <= '0;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
        end
    end

    assign sof_out = active_in && (col_q == '0) && (line_q == '0);
    assign eol_out = active_in && col_last;
    assign eof_out = eol_out && line_last;

endmodule

// File: rtl/rgb_expand.sv
// Expands 3-bit compressed colour codes into REPEAT full-depth RGB pixels
// with line/frame position markers.
module rgb_expand
    import rgb_pkg::*;
#(
    parameter int unsigned COLOUR_DEPTH = 8,
    parameter int unsigned REPEAT       = 3,
    parameter int unsigned LOW_LEVEL    = 0,
    parameter int unsigned HIGH_LEVEL   = 255,
    parameter int unsigned LINE_WIDTH   = 640,
    parameter int unsigned NUM_LINES    = 480
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [2:0]                code_in,
    input  logic                      code_valid_in,
    output logic                      code_ready_out,
    input  logic                      frame_restart_in,
    output logic [3*COLOUR_DEPTH-1:0] rgb_out,
    output logic                      rgb_valid_out,
    input  logic                      rgb_ready_in,
    output logic                      sof_out,
    output logic                      eol_out,
    output logic                      eof_out
);

    localparam int unsigned REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    state_t           state_q, state_d;
    logic [2:0]       code_q,  code_d;
    logic [REP_W-1:0] rep_q,   rep_d;

    logic busy;
    logic last_rep;
    logic in_fire;
    logic out_fire;

    logic [COLOUR_DEPTH-1:0] r_lvl, g_lvl, b_lvl;

    assign busy     = (state_q == ST_EMIT);
    assign last_rep = (rep_q == REP_W'(REPEAT - 1));

    // Ready is gated by reset so the port reads 0 while reset is held,
    // even though the idle state would otherwise advertise readiness.
    assign code_ready_out = rst_n_in && !frame_restart_in &&
                            (!busy || (rgb_ready_in && last_rep));

    assign in_fire  = code_valid_in && code_ready_out;
    assign out_fire = rgb_valid_out && rgb_ready_in;

    // Handshake/repeat control: restart, accept, finish, then step
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rep_d   = rep_q;
        if (frame_restart_in) begin
            state_d = ST_IDLE;
            rep_d   = '0;
        end else if (in_fire) begin
            state_d = ST_EMIT;
            code_d  = code_in;
            rep_d   = '0;
        end else if (out_fire && last_rep) begin
            state_d = ST_IDLE;
            rep_d   = '0;
        end else if (out_fire) begin
            rep_d = rep_q + REP_W'(1);
        end
    end

    // Control registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            rep_q   <= rep_d;
        end
    end

    // Channel expansion from the held code
    always_comb begin
        r_lvl = COLOUR_DEPTH'(channel_level(code_q[R_BIT], LOW_LEVEL, HIGH_LEVEL));
        g_lvl = COLOUR_DEPTH'(channel_level(code_q[G_BIT], LOW_LEVEL, HIGH_LEVEL));
        b_lvl = COLOUR_DEPTH'(channel_level(code_q[B_BIT], LOW_LEVEL, HIGH_LEVEL));
    end

    assign rgb_valid_out = busy;
    assign rgb_out       = busy ? {r_lvl, g_lvl, b_lvl} : '0;

    frame_pos_counter #(
        .LINE_WIDTH (LINE_WIDTH),
        .NUM_LINES  (NUM_LINES)
    ) u_pos (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .active_in  (busy),
        .advance_in (out_fire && !frame_restart_in),
        .clear_in   (frame_restart_in),
        .sof_out    (sof_out),
        .eol_out    (eol_out),
        .eof_out    (eof_out)
    );

endmodule

// File: tb/tb_rgb_expand.sv
// Directed bench for rgb_expand with a pixel scoreboard.
module tb_rgb_expand;

    localparam int unsigned CD  = 8;
    localparam int unsigned REP = 3;
    localparam int unsigned LW  = 4;
    localparam int unsigned NL  = 2;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic [2:0]    code_in = '0;
    logic          code_valid_in = 1'b0;
    logic          code_ready_out;
    logic          frame_restart_in = 1'b0;
    logic [3*CD-1:0] rgb_out;
    logic          rgb_valid_out;
    logic          rgb_ready_in = 1'b1;
    logic          sof_out, eol_out, eof_out;

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   fires = 0;
    int   sof_cnt = 0, eol_cnt = 0, eof_cnt = 0;
    int   cyc = 0;
    int   m_col = 0, m_line = 0;

    rgb_expand #(
        .COLOUR_DEPTH (CD),
        .REPEAT       (REP),
        .LOW_LEVEL    (0),
        .HIGH_LEVEL   (255),
        .LINE_WIDTH   (LW),
        .NUM_LINES    (NL)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .code_in          (code_in),
        .code_valid_in    (code_valid_in),
        .code_ready_out   (code_ready_out),
        .frame_restart_in (frame_restart_in),
        .rgb_out          (rgb_out),
        .rgb_valid_out    (rgb_valid_out),
        .rgb_ready_in     (rgb_ready_in),
        .sof_out          (sof_out),
        .eol_out          (eol_out),
        .eof_out          (eof_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected pixels for one accepted code, positioned by the bench's own counters
    task automatic push_code(input logic [2:0] c);
        pix_t p;
        for (int r = 0; r < REP; r++) begin
            p.rgb = {c[2] ? 8'hFF : 8'h00, c[1] ? 8'hFF : 8'h00, c[0] ? 8'hFF : 8'h00};
            p.sof = (m_col == 0) && (m_line == 0);
            p.eol = (m_col == LW - 1);
            p.eof = p.eol && (m_line == NL - 1);
            exp_q.push_back(p);
            if (m_col == LW - 1) begin
                m_col  = 0;
                m_line = (m_line == NL - 1) ? 0 : m_line + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_col  = 0;
        m_line = 0;
    endtask

    // Leaves code_valid_in high; returns 1 time unit after the accepting edge
    task automatic send_code(input logic [2:0] c);
        logic acc;
        acc = 1'b0;
        code_in = c;
        code_valid_in = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk_in);
            if (code_ready_out) begin
                acc = 1'b1;
                push_code(c);
            end
            @(posedge clk_in); #1;
        end
        chk("accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk_in); #1;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic restart_pulse();
        frame_restart_in = 1'b1;
        @(negedge clk_in);
        chk("restart_ready", {31'd0, code_ready_out}, 32'd0);
        @(posedge clk_in);
        clear_model();
        #1;
        frame_restart_in = 1'b0;
    endtask

    // Scoreboard monitor: compare presented pixel with queue head, pop on fire
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (rgb_valid_out) begin
                chk("pixel_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    chk("rgb", {8'd0, rgb_out}, {8'd0, exp_q[0].rgb});
                    chk("sof", {31'd0, sof_out}, {31'd0, exp_q[0].sof});
                    chk("eol", {31'd0, eol_out}, {31'd0, exp_q[0].eol});
                    chk("eof", {31'd0, eof_out}, {31'd0, exp_q[0].eof});
                    if (rgb_ready_in && !frame_restart_in) begin
                        void'(exp_q.pop_front());
                        fires++;
                        if (sof_out) sof_cnt++;
                        if (eol_out) eol_cnt++;
                        if (eof_out) eof_cnt++;
                    end
                end
            end else begin
                chk("idle_outputs", {5'd0, rgb_out, sof_out, eol_out, eof_out}, 32'd0);
            end
        end
    end

    initial begin
        int f0, c0, s0, e0, x0;

        // Reset state
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid", {31'd0, rgb_valid_out}, 32'd0);
        chk("rst_rgb", {8'd0, rgb_out}, 32'd0);
        chk("rst_ready", {31'd0, code_ready_out}, 32'd0);
        chk("rst_markers", {29'd0, sof_out, eol_out, eof_out}, 32'd0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        // Single code 101
        send_code(3'b101);
        code_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("t1_valid", {31'd0, rgb_valid_out}, 32'd1);
            chk("t1_rgb", {8'd0, rgb_out}, 32'h00FF00FF);
            chk("t1_ready", {31'd0, code_ready_out}, (i == 2) ? 32'd1 : 32'd0);
            @(posedge clk_in); #1;
        end
        @(negedge clk_in);
        chk("t1_end_valid", {31'd0, rgb_valid_out}, 32'd0);
        @(posedge clk_in); #1;

        // Back-to-back 010, 001
        send_code(3'b010);
        f0 = fires;
        c0 = cyc;
        send_code(3'b001);
        code_valid_in = 1'b0;
        chk("t2_fires_first", fires - f0, 32'd3);
        chk("t2_cycles", cyc - c0, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("t2_valid", {31'd0, rgb_valid_out}, 32'd1);
            @(posedge clk_in); #1;
        end
        @(negedge clk_in);
        chk("t2_end_valid", {31'd0, rgb_valid_out}, 32'd0);
        chk("t2_fires", fires - f0, 32'd6);
        @(posedge clk_in); #1;

        // Stalled output on code 111
        send_code(3'b111);
        code_valid_in = 1'b0;
        f0 = fires;
        for (int i = 0; i < 7; i++) begin
            rgb_ready_in = (i % 3 == 0);
            @(negedge clk_in);
            chk("t3_valid", {31'd0, rgb_valid_out}, 32'd1);
            chk("t3_rgb", {8'd0, rgb_out}, 32'h00FFFFFF);
            chk("t3_ready", {31'd0, code_ready_out}, (i == 6) ? 32'd1 : 32'd0);
            @(posedge clk_in); #1;
        end
        rgb_ready_in = 1'b1;
        @(negedge clk_in);
        chk("t3_fires", fires - f0, 32'd3);
        chk("t3_end_valid", {31'd0, rgb_valid_out}, 32'd0);
        @(posedge clk_in); #1;

        // Position markers over 9 pixels on a 4x2 frame
        restart_pulse();
        s0 = sof_cnt; e0 = eol_cnt; x0 = eof_cnt;
        send_code(3'b100);
        send_code(3'b010);
        send_code(3'b110);
        code_valid_in = 1'b0;
        drain();
        chk("t4_sof_cnt", sof_cnt - s0, 32'd2);
        chk("t4_eol_cnt", eol_cnt - e0, 32'd2);
        chk("t4_eof_cnt", eof_cnt - x0, 32'd1);

        // Restart at rep 1 with a code pending
        send_code(3'b110);
        code_in = 3'b011;
        @(posedge clk_in); #1;
        frame_restart_in = 1'b1;
        @(negedge clk_in);
        chk("t5_ready", {31'd0, code_ready_out}, 32'd0);
        @(posedge clk_in);
        clear_model();
        #1;
        frame_restart_in = 1'b0;
        code_valid_in = 1'b0;
        chk("t5_valid", {31'd0, rgb_valid_out}, 32'd0);
        chk("t5_rgb", {8'd0, rgb_out}, 32'd0);
        send_code(3'b011);
        code_valid_in = 1'b0;
        @(negedge clk_in);
        chk("t5_sof", {31'd0, sof_out}, 32'd1);
        @(posedge clk_in); #1;
        drain();

        // Asynchronous reset mid-emission
        send_code(3'b100);
        code_valid_in = 1'b0;
        #2;
        rst_n_in = 1'b0;
        clear_model();
        #1;
        chk("t6_valid", {31'd0, rgb_valid_out}, 32'd0);
        chk("t6_rgb", {8'd0, rgb_out}, 32'd0);
        chk("t6_ready", {31'd0, code_ready_out}, 32'd0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        send_code(3'b001);
        code_valid_in = 1'b0;
        @(negedge clk_in);
        chk("t6_sof", {31'd0, sof_out}, 32'd1);
        chk("t6_rgb_after", {8'd0, rgb_out}, 32'h000000FF);
        @(posedge clk_in); #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
